mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, address width.
REQ-002 SHALL have parameter DATA_W, 32, data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, 255, BUSY cycles before abort (timeout build only).
REQ-004 SHALL have port clk  in  1  single clock, rising-edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-006 SHALL have ports mN_req  in  1  request from master N, N in {0,1}; 0 = CPU control, 1 = DMA/debug.
REQ-007 SHALL have ports mN_rw  in  1  write if 1.
REQ-008 SHALL have ports mN_addr  in  ADDR_W  request address.
REQ-009 SHALL have ports mN_wdata  in  DATA_W  write data.
REQ-010 SHALL have ports mN_rdata  out  DATA_W  read data, registered.
REQ-011 SHALL have ports mN_ack  out  1  one-cycle completion pulse.
REQ-012 SHALL have ports mN_err  out  1  completion was a timeout abort; valid with mN_ack.
REQ-013 SHALL have port mem_req  out  1  memory access in progress.
REQ-014 SHALL have port mem_rw  out  1  write if 1.
REQ-015 SHALL have port mem_address  out  ADDR_W  latched address.
REQ-016 SHALL have port mem_data_out  out  DATA_W  latched write data.
REQ-017 SHALL have port mem_data_in  in  DATA_W  read data from memory.
REQ-018 SHALL have port mem_ready  in  1  memory completes the access this cycle.

Function
REQ-019 SHALL implement FSM states IDLE, BUSY, ACK.
REQ-020 IDLE: if any mN_req is 1, SHALL latch the winner's rw/addr/wdata and go to BUSY next edge; otherwise stay in IDLE.
REQ-021 Arbitration SHALL be round-robin: on simultaneous requests the master not granted last wins; after reset, m0 wins.
REQ-022 BUSY: mem_req SHALL be 1; mem_rw/mem_address/mem_data_out SHALL be held from the latched values.
REQ-023 BUSY with mem_ready=1: SHALL go to ACK; on a read, SHALL capture mem_data_in into the granted mN_rdata.
REQ-024 ACK: SHALL assert the granted mN_ack for exactly one cycle with mem_req=0, then go to IDLE.
REQ-025 Latency: req sampled at edge 0, mem_req high after edge 1, mem_ready at edge k, ack high for the cycle after edge k.
REQ-026 mN_rdata SHALL be unchanged by writes, by the other master's accesses, and by timeouts.
REQ-027 A master SHALL hold req and its signals stable until ack; req still high in the IDLE cycle after ACK SHALL be treated as a new request.
REQ-028 mem_ready SHALL be ignored in IDLE and ACK.
REQ-029 Changes to the requester's inputs during BUSY SHALL NOT affect the memory outputs.

Reset
REQ-030 reset=0 SHALL asynchronously force IDLE, mem_req=0, mem_rw=0, mem_address=0, mem_data_out=0, mN_ack=0, mN_err=0, mN_rdata=0, and round-robin pointer to favour m0.
REQ-031 Reset asserted during BUSY SHALL abort the access with no ack.

Configuration
REQ-032 Macro MEM_ARBITER_TIMEOUT_EN defined: a counter SHALL run in BUSY. When it reaches TIMEOUT_CYCLES without mem_ready, the block SHALL go to ACK with mN_ack=1 and mN_err=1, and mem_req SHALL drop.
REQ-033 Macro MEM_ARBITER_TIMEOUT_EN undefined: no counter, mN_err SHALL be tied 0, and BUSY SHALL wait indefinitely.

Structure
REQ-034 Shared package funny_bus_pkg SHALL hold the state enum (IDLE, BUSY, ACK) and the ADDR_W/DATA_W defaults.
REQ-035 The two-way round-robin pick (requests plus last-grant in, one-hot grant out) SHALL be the sub-module arb_rr2.

Verification
REQ-036 m0 read addr 0x100, mem_ready 2 cycles after mem_req, mem_data_in=0xDEADBEEF -> m0_ack one cycle, m0_rdata=0xDEADBEEF, m1 signals untouched.
REQ-037 m0 and m1 request together from reset -> m0 served first, then m1; repeat both -> m1 first, then m0.
REQ-038 m1 write addr 0x20 data 0x12345678 -> mem_rw=1, mem_address=0x20, mem_data_out=0x12345678 held through BUSY; m1_rdata unchanged.
REQ-039 Reset pulsed low during BUSY -> all outputs 0 immediately, no ack; the next m1 request after reset is served normally.
REQ-040 With MEM_ARBITER_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready never asserted -> m0_ack=1 and m0_err=1 in the cycle after 4 BUSY cycles; without the macro, mem_req stays 1.

Source files
------------

// File: rtl/funny_bus_pkg.sv
// Shared state encoding and default bus widths for the two-master memory arbiter.
package funny_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports and the memory port of mem_arbiter.
// slave is the arbiter's view; master is the requesters-plus-memory view.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = funny_bus_pkg::ADDR_W_DEF,
  parameter int unsigned DATA_W = funny_bus_pkg::DATA_W_DEF
) ();

  logic              m0_req;
  logic              m0_rw;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack;
  logic              m0_err;

  logic              m1_req;
  logic              m1_rw;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack;
  logic              m1_err;

  logic              mem_req;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_out;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_ready;

  modport slave (
    input  m0_req, m0_rw, m0_addr, m0_wdata,
    output m0_rdata, m0_ack, m0_err,
    input  m1_req, m1_rw, m1_addr, m1_wdata,
    output m1_rdata, m1_ack, m1_err,
    output mem_req, mem_rw, mem_address, mem_data_out,
    input  mem_data_in, mem_ready
  );

  modport master (
    output m0_req, m0_rw, m0_addr, m0_wdata,
    input  m0_rdata, m0_ack, m0_err,
    output m1_req, m1_rw, m1_addr, m1_wdata,
    input  m1_rdata, m1_ack, m1_err,
    input  mem_req, mem_rw, mem_address, mem_data_out,
    output mem_data_in, mem_ready
  );

endinterface

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: on a tie the master not granted last wins.
module arb_rr2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant_c
);

  always_comb begin
    grant_c = 2'b00;
    case (req)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = last ? 2'b01 : 2'b10;
      default: grant_c = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-master round-robin memory arbiter with IDLE/BUSY/ACK sequencing.
// Optional BUSY abort counter is built when MEM_ARBITER_TIMEOUT_EN is defined.
module mem_arbiter
  import funny_bus_pkg::*;
#(
  parameter int unsigned ADDR_W         = ADDR_W_DEF,
  parameter int unsigned DATA_W         = DATA_W_DEF,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_e            state;
  logic              cur;         // index of the master being served
  logic              last_grant;  // index of the master granted most recently
  logic              mem_req_q;
  logic              mem_rw_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              ack0_q;
  logic              ack1_q;

  logic [1:0]        req_c;
  logic [1:0]        grant_c;
  logic              any_c;
  logic              sel_c;
  logic              rw_c;
  logic [ADDR_W-1:0] addr_c;
  logic [DATA_W-1:0] wdata_c;

  assign req_c = {bus.m1_req, bus.m0_req};

  arb_rr2 u_arb (
    .req     (req_c),
    .last    (last_grant),
    .grant_c (grant_c)
  );

  assign any_c   = |grant_c;
  assign sel_c   = grant_c[1];
  assign rw_c    = sel_c ? bus.m1_rw    : bus.m0_rw;
  assign addr_c  = sel_c ? bus.m1_addr  : bus.m0_addr;
  assign wdata_c = sel_c ? bus.m1_wdata : bus.m0_wdata;

`ifdef MEM_ARBITER_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CNT_W-1:0] cnt_q;
  logic             err0_q;
  logic             err1_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cur         <= 1'b0;
      last_grant  <= 1'b1;
      mem_req_q   <= 1'b0;
      mem_rw_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      cnt_q       <= '0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
`endif
    end else begin
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
`ifdef MEM_ARBITER_TIMEOUT_EN
      err0_q <= 1'b0;
      err1_q <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_c) begin
            state       <= BUSY;
            cur         <= sel_c;
            last_grant  <= sel_c;
            mem_req_q   <= 1'b1;
            mem_rw_q    <= rw_c;
            mem_addr_q  <= addr_c;
            mem_wdata_q <= wdata_c;
`ifdef MEM_ARBITER_TIMEOUT_EN
            cnt_q       <= '0;
`endif
          end
        end
        BUSY: begin
          if (bus.mem_ready) begin
            state     <= ACK;
            mem_req_q <= 1'b0;
            ack0_q    <= ~cur;
            ack1_q    <= cur;
            if (!mem_rw_q) begin
              if (cur) rdata1_q <= bus.mem_data_in;
              else     rdata0_q <= bus.mem_data_in;
            end
          end
`ifdef MEM_ARBITER_TIMEOUT_EN
          // Abort at the end of the TIMEOUT_CYCLES-th BUSY cycle; read data is left alone.
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state     <= ACK;
            mem_req_q <= 1'b0;
            ack0_q    <= ~cur;
            ack1_q    <= cur;
            err0_q    <= ~cur;
            err1_q    <= cur;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req      = mem_req_q;
  assign bus.mem_rw       = mem_rw_q;
  assign bus.mem_address  = mem_addr_q;
  assign bus.mem_data_out = mem_wdata_q;
  assign bus.m0_rdata     = rdata0_q;
  assign bus.m1_rdata     = rdata1_q;
  assign bus.m0_ack       = ack0_q;
  assign bus.m1_ack       = ack1_q;

`ifdef MEM_ARBITER_TIMEOUT_EN
  assign bus.m0_err = err0_q;
  assign bus.m1_err = err1_q;
`else
  assign bus.m0_err = 1'b0;
  assign bus.m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// against a transaction-level round-robin model.
module tb_mem_arbiter;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   rr_last;
  logic [31:0] exp_rdata [2];

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int m, input logic req, input logic rw,
                       input logic [31:0] a, input logic [31:0] d);
    if (m == 0) begin
      bus.m0_req = req; bus.m0_rw = rw; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = req; bus.m1_rw = rw; bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    set_m(0, 1'b0, 1'b0, 32'h0, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0, 32'h0);
    bus.mem_ready = 1'b0;
    bus.mem_data_in = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({bus.mem_req, bus.mem_rw, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err} !== 6'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 000000",
        {bus.mem_req, bus.mem_rw, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err});
    end
    total++;
    if ({bus.mem_address, bus.mem_data_out, bus.m0_rdata, bus.m1_rdata} !== 128'h0) begin
      bad++; $display("FAIL reset_data: got %h want 0",
        {bus.mem_address, bus.mem_data_out, bus.m0_rdata, bus.m1_rdata});
    end
    reset = 1'b1;
    rr_last = 1;
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
    // mem_ready in IDLE must not start or complete anything
    bus.mem_ready = 1'b1;
    bus.mem_data_in = 32'hFFFF_FFFF;
    repeat (3) begin
      tick();
      total++;
      if ({bus.mem_req, bus.m0_ack, bus.m1_ack} !== 3'b0) begin
        bad++; $display("FAIL idle_ready: got %b want 000", {bus.mem_req, bus.m0_ack, bus.m1_ack});
      end
    end
    total++;
    if ({bus.m0_rdata, bus.m1_rdata} !== 64'h0) begin
      bad++; $display("FAIL idle_rdata: got %h want 0", {bus.m0_rdata, bus.m1_rdata});
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_simultaneous();
    int          order [4] = '{0, 1, 0, 1};
    int          w;
    logic [31:0] d;
    set_m(0, 1'b1, 1'b0, 32'h0000_0A00, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h0000_0B00, 32'h0);
    for (int i = 0; i < 4; i++) begin
      w = order[i];
      tick();
      total++;
      if ({bus.mem_req, bus.mem_address} !== {1'b1, (w == 1) ? 32'h0000_0B00 : 32'h0000_0A00}) begin
        bad++; $display("FAIL rr_grant%0d: got req=%b addr=%h want master %0d", i,
          bus.mem_req, bus.mem_address, w);
      end
      d = 32'h5100_0000 + 32'(i);
      bus.mem_ready = 1'b1;
      bus.mem_data_in = d;
      tick();
      bus.mem_ready = 1'b0;
      exp_rdata[w] = d;
      total++;
      if ({bus.m1_ack, bus.m0_ack} !== ((w == 1) ? 2'b10 : 2'b01)) begin
        bad++; $display("FAIL rr_ack%0d: got m1m0=%b want master %0d", i, {bus.m1_ack, bus.m0_ack}, w);
      end
      total++;
      if ({bus.m0_rdata, bus.m1_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin
        bad++; $display("FAIL rr_rdata%0d: got %h want %h", i,
          {bus.m0_rdata, bus.m1_rdata}, {exp_rdata[0], exp_rdata[1]});
      end
      if (i == 3) begin
        bus.m0_req = 1'b0;
        bus.m1_req = 1'b0;
      end
      tick();
      total++;
      if ({bus.m1_ack, bus.m0_ack, bus.mem_req} !== 3'b0) begin
        bad++; $display("FAIL rr_ack_once%0d: got %b want 000", i, {bus.m1_ack, bus.m0_ack, bus.mem_req});
      end
    end
    rr_last = 1;
  endtask

  task automatic test_read();
    set_m(0, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
    set_m(1, 1'b0, 1'b0, 32'h0000_0777, 32'h1111_2222);
    tick();
    total++;
    if ({bus.mem_req, bus.mem_rw, bus.mem_address} !== {1'b1, 1'b0, 32'h0000_0100}) begin
      bad++; $display("FAIL rd_start: got req=%b rw=%b addr=%h want 1 0 00000100",
        bus.mem_req, bus.mem_rw, bus.mem_address);
    end
    tick();
    total++;
    if ({bus.mem_req, bus.m0_ack} !== 2'b10) begin
      bad++; $display("FAIL rd_wait: got req/ack=%b want 10", {bus.mem_req, bus.m0_ack});
    end
    bus.mem_ready = 1'b1;
    bus.mem_data_in = 32'hDEAD_BEEF;
    tick();
    bus.mem_ready = 1'b0;
    exp_rdata[0] = 32'hDEAD_BEEF;
    rr_last = 0;
    total++;
    if ({bus.m0_ack, bus.m0_err, bus.m1_ack, bus.mem_req} !== 4'b1000) begin
      bad++; $display("FAIL rd_ack: got ack0/err0/ack1/req=%b want 1000",
        {bus.m0_ack, bus.m0_err, bus.m1_ack, bus.mem_req});
    end
    total++;
    if ({bus.m0_rdata, bus.m1_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin
      bad++; $display("FAIL rd_data: got %h want %h", {bus.m0_rdata, bus.m1_rdata},
        {exp_rdata[0], exp_rdata[1]});
    end
    bus.m0_req = 1'b0;
    tick();
    total++;
    if ({bus.m0_ack, bus.m1_ack} !== 2'b00) begin
      bad++; $display("FAIL rd_ack_once: got %b want 00", {bus.m0_ack, bus.m1_ack});
    end
  endtask

  task automatic test_write();
    set_m(1, 1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678);
    tick();
    total++;
    if ({bus.mem_req, bus.mem_rw, bus.mem_address, bus.mem_data_out} !==
        {1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678}) begin
      bad++; $display("FAIL wr_start: got %b %b %h %h want 1 1 00000020 12345678",
        bus.mem_req, bus.mem_rw, bus.mem_address, bus.mem_data_out);
    end
    // requester inputs wobble during BUSY; the memory side must not follow
    for (int i = 0; i < 2; i++) begin
      set_m(1, 1'b1, 1'b0, $urandom, $urandom);
      tick();
      total++;
      if ({bus.mem_req, bus.mem_rw, bus.mem_address, bus.mem_data_out} !==
          {1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678}) begin
        bad++; $display("FAIL wr_hold%0d: got %b %b %h %h", i,
          bus.mem_req, bus.mem_rw, bus.mem_address, bus.mem_data_out);
      end
    end
    bus.mem_ready = 1'b1;
    bus.mem_data_in = 32'hBAAD_CAFE;
    tick();
    bus.mem_ready = 1'b0;
    rr_last = 1;
    total++;
    if ({bus.m1_ack, bus.m1_err, bus.m0_ack, bus.mem_req} !== 4'b1000) begin
      bad++; $display("FAIL wr_ack: got ack1/err1/ack0/req=%b want 1000",
        {bus.m1_ack, bus.m1_err, bus.m0_ack, bus.mem_req});
    end
    total++;
    if ({bus.m0_rdata, bus.m1_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin
      bad++; $display("FAIL wr_rdata: got %h want %h", {bus.m0_rdata, bus.m1_rdata},
        {exp_rdata[0], exp_rdata[1]});
    end
    bus.m1_req = 1'b0;
    tick();
  endtask

  task automatic test_random();
    bit          pend  [2];
    logic        p_rw  [2];
    logic [31:0] p_addr[2];
    logic [31:0] p_wd  [2];
    int          win;
    int          oth;
    int          lat;
    logic [31:0] rd;
    pend[0] = 1'b0;
    pend[1] = 1'b0;
    for (int it = 0; it < 60; it++) begin
      if (it >= 40 && !pend[0] && !pend[1]) break;
      if (it < 40) begin
        for (int m = 0; m < 2; m++) begin
          if (!pend[m] && $urandom_range(0, 9) < 6) begin
            pend[m] = 1'b1; p_rw[m] = 1'($urandom); p_addr[m] = $urandom; p_wd[m] = $urandom;
          end
        end
        if (!pend[0] && !pend[1]) begin
          win = int'($urandom_range(0, 1));
          pend[win] = 1'b1; p_rw[win] = 1'($urandom); p_addr[win] = $urandom; p_wd[win] = $urandom;
        end
      end
      for (int m = 0; m < 2; m++) begin
        if (pend[m]) set_m(m, 1'b1, p_rw[m], p_addr[m], p_wd[m]);
        else         set_m(m, 1'b0, 1'($urandom), $urandom, $urandom);
      end
      bus.mem_ready = 1'b0;
      // reference pick: the only requester, or on a tie the one not granted last
      win = (pend[0] && pend[1]) ? 1 - rr_last : (pend[0] ? 0 : 1);
      oth = 1 - win;
      tick();
      total++;
      if ({bus.mem_req, bus.mem_rw, bus.mem_address, bus.mem_data_out} !==
          {1'b1, p_rw[win], p_addr[win], p_wd[win]}) begin
        bad++; $display("FAIL rnd_start%0d: got %b %b %h %h want master %0d %b %h %h", it,
          bus.mem_req, bus.mem_rw, bus.mem_address, bus.mem_data_out, win,
          p_rw[win], p_addr[win], p_wd[win]);
      end
      lat = int'($urandom_range(1, 4));
      rd = 32'h0;
      for (int j = 1; j <= lat; j++) begin
        rd = $urandom;
        bus.mem_data_in = rd;
        bus.mem_ready = (j == lat);
        if (!pend[oth]) set_m(oth, 1'b0, 1'($urandom), $urandom, $urandom);
        tick();
        if (j < lat) begin
          total++;
          if ({bus.mem_req, bus.mem_address, bus.m0_ack, bus.m1_ack} !== {1'b1, p_addr[win], 2'b00}) begin
            bad++; $display("FAIL rnd_busy%0d: got req=%b addr=%h acks=%b want 1 %h 00", it,
              bus.mem_req, bus.mem_address, {bus.m0_ack, bus.m1_ack}, p_addr[win]);
          end
        end
      end
      bus.mem_ready = 1'($urandom);
      if (!p_rw[win]) exp_rdata[win] = rd;
      total++;
      if ({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.mem_req} !==
          {(win == 0), (win == 1), 3'b000}) begin
        bad++; $display("FAIL rnd_ack%0d: got ack0/ack1/err0/err1/req=%b want master %0d", it,
          {bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err, bus.mem_req}, win);
      end
      total++;
      if ({bus.m0_rdata, bus.m1_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin
        bad++; $display("FAIL rnd_rdata%0d: got %h want %h", it,
          {bus.m0_rdata, bus.m1_rdata}, {exp_rdata[0], exp_rdata[1]});
      end
      pend[win] = 1'b0;
      rr_last = win;
      set_m(win, 1'b0, p_rw[win], p_addr[win], p_wd[win]);
      tick();
      total++;
      if ({bus.m0_ack, bus.m1_ack, bus.mem_req} !== 3'b000) begin
        bad++; $display("FAIL rnd_done%0d: got %b want 000", it, {bus.m0_ack, bus.m1_ack, bus.mem_req});
      end
    end
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset_busy();
    set_m(0, 1'b1, 1'b1, 32'h0000_0040, 32'h0000_55AA);
    tick();
    tick();
    total++;
    if ({bus.mem_req, bus.mem_rw, bus.mem_address} !== {1'b1, 1'b1, 32'h0000_0040}) begin
      bad++; $display("FAIL rb_busy: got %b %b %h want 1 1 00000040",
        bus.mem_req, bus.mem_rw, bus.mem_address);
    end
    #2 reset = 1'b0;
    #1;
    exp_rdata[0] = 32'h0;
    exp_rdata[1] = 32'h0;
    rr_last = 1;
    total++;
    if ({bus.mem_req, bus.mem_rw, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err,
         bus.mem_address, bus.mem_data_out, bus.m0_rdata, bus.m1_rdata} !== 134'h0) begin
      bad++; $display("FAIL rb_async: got %b %h %h %h %h want all 0",
        {bus.mem_req, bus.mem_rw, bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err},
        bus.mem_address, bus.mem_data_out, bus.m0_rdata, bus.m1_rdata);
    end
    bus.m0_req = 1'b0;
    bus.mem_ready = 1'b1;
    tick();
    reset = 1'b1;
    bus.mem_ready = 1'b0;
    repeat (2) begin
      tick();
      total++;
      if ({bus.mem_req, bus.m0_ack, bus.m1_ack} !== 3'b000) begin
        bad++; $display("FAIL rb_noack: got %b want 000", {bus.mem_req, bus.m0_ack, bus.m1_ack});
      end
    end
    set_m(1, 1'b1, 1'b0, 32'h0000_0080, 32'h0);
    tick();
    total++;
    if ({bus.mem_req, bus.mem_rw, bus.mem_address} !== {1'b1, 1'b0, 32'h0000_0080}) begin
      bad++; $display("FAIL rb_next_start: got %b %b %h want 1 0 00000080",
        bus.mem_req, bus.mem_rw, bus.mem_address);
    end
    bus.mem_ready = 1'b1;
    bus.mem_data_in = 32'hCAFE_F00D;
    tick();
    bus.mem_ready = 1'b0;
    exp_rdata[1] = 32'hCAFE_F00D;
    rr_last = 1;
    total++;
    if ({bus.m1_ack, bus.m0_ack, bus.m0_rdata, bus.m1_rdata} !==
        {2'b10, exp_rdata[0], exp_rdata[1]}) begin
      bad++; $display("FAIL rb_next_ack: got %b %h %h want 10 %h %h", {bus.m1_ack, bus.m0_ack},
        bus.m0_rdata, bus.m1_rdata, exp_rdata[0], exp_rdata[1]);
    end
    bus.m1_req = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int drops;
    set_m(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
    bus.mem_ready = 1'b0;
    bus.mem_data_in = 32'h7777_7777;
    tick();
    total++;
    if (bus.mem_req !== 1'b1) begin
      bad++; $display("FAIL to_start: got mem_req=%b want 1", bus.mem_req);
    end
`ifdef MEM_ARBITER_TIMEOUT_EN
    drops = 0;
    repeat (3) begin
      tick();
      if ({bus.mem_req, bus.m0_ack} !== 2'b10) drops++;
    end
    total++;
    if (drops != 0) begin
      bad++; $display("FAIL to_early: got %0d early-ending cycles want 0", drops);
    end
    tick();
    total++;
    if ({bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err, bus.mem_req} !== 5'b11000) begin
      bad++; $display("FAIL to_abort: got ack0/err0/ack1/err1/req=%b want 11000",
        {bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err, bus.mem_req});
    end
    total++;
    if ({bus.m0_rdata, bus.m1_rdata} !== {exp_rdata[0], exp_rdata[1]}) begin
      bad++; $display("FAIL to_rdata: got %h want %h", {bus.m0_rdata, bus.m1_rdata},
        {exp_rdata[0], exp_rdata[1]});
    end
    bus.m0_req = 1'b0;
    tick();
    total++;
    if ({bus.m0_ack, bus.m0_err} !== 2'b00) begin
      bad++; $display("FAIL to_once: got ack0/err0=%b want 00", {bus.m0_ack, bus.m0_err});
    end
`else
    drops = 0;
    repeat (20) begin
      tick();
      if ({bus.mem_req, bus.m0_ack, bus.m0_err} !== 3'b100) drops++;
    end
    total++;
    if (drops != 0) begin
      bad++; $display("FAIL to_wait: got %0d cycles not waiting want 0", drops);
    end
    bus.mem_ready = 1'b1;
    bus.mem_data_in = 32'h0BAD_F00D;
    tick();
    bus.mem_ready = 1'b0;
    exp_rdata[0] = 32'h0BAD_F00D;
    total++;
    if ({bus.m0_ack, bus.m0_err, bus.mem_req, bus.m0_rdata} !== {3'b100, exp_rdata[0]}) begin
      bad++; $display("FAIL to_late_ack: got %b %h want 100 %h",
        {bus.m0_ack, bus.m0_err, bus.mem_req}, bus.m0_rdata, exp_rdata[0]);
    end
    bus.m0_req = 1'b0;
    tick();
`endif
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset();
    test_simultaneous();
    test_read();
    test_write();
    test_random();
    test_reset_busy();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
